// File: rtl/cle02b_sdrd_capture.sv
// Deserialiser for the CLE02b PAL serial response, feeding a 2-entry valid/ready buffer.
// Optional odd-parity checking of each word is enabled by defining PARITY_CHK_EN.
module cle02b_sdrd_capture #(
    parameter int WIDTH     = 8,
    parameter int TIMEOUT   = 1023,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_stb,
    input  logic                     SSER,
    input  logic                     BA13,
    input  logic                     BA12,
    input  logic                     BR_W,
    input  logic                     SDRD,
    input  logic                     P12,
    input  logic                     Q3,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     ovf,
    output logic                     tmo,
`ifdef PARITY_CHK_EN
    output logic                     perr,
`endif
    input  logic                     err_clr
);

`ifdef PARITY_CHK_EN
    localparam int WL = WIDTH + 1;
`else
    localparam int WL = WIDTH;
`endif
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_CNT = BW'(WL - 1);
    localparam logic [16:0]   TMO_LIM  = 17'(TIMEOUT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_par_ok(input logic [WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction

    state_t            state_q, state_d;
    logic [WL-1:0]     sr_q, sr_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [WIDTH-1:0]  e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        fill_q, fill_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic              perr_q, perr_d;

    logic              qual_s, bit_s;
    logic [WL-1:0]     base_s, sr_ins_s;
    logic [WIDTH-1:0]  word_s;
    logic              par_bit_s;
    logic              word_done_s, tmo_ev_s, ovf_ev_s, perr_ev_s;
    logic              push_s, pop_s;

    assign qual_s = acc_stb & ~SSER & ~BA13 & BA12 & BR_W;
    assign bit_s  = Q3 ? P12 : SDRD;

    // Shift-register insertion point; a fresh word starts from zero.
    always_comb begin
        base_s = (state_q == ST_IDLE) ? {WL{1'b0}} : sr_q;
        if (MSB_FIRST != 0) begin
            sr_ins_s = {base_s[WL-2:0], bit_s};
        end else begin
            sr_ins_s = {bit_s, base_s[WL-1:1]};
        end
    end

    // Split the just-completed frame into data and (optional) parity bit.
    always_comb begin
        word_s    = {WIDTH{1'b0}};
        par_bit_s = 1'b1;
`ifdef PARITY_CHK_EN
        if (MSB_FIRST != 0) begin
            word_s    = sr_ins_s[WL-1:1];
            par_bit_s = sr_ins_s[0];
        end else begin
            word_s    = sr_ins_s[WIDTH-1:0];
            par_bit_s = sr_ins_s[WL-1];
        end
`else
        word_s = sr_ins_s[WIDTH-1:0];
`endif
    end

    // Capture FSM: bit counting, word completion and mid-word inactivity timeout.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        word_done_s = 1'b0;
        tmo_ev_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = 16'd0;
                if (qual_s) begin
                    sr_d      = sr_ins_s;
                    bit_cnt_d = BW'(1);
                    state_d   = ST_SHIFT;
                end else begin
                    bit_cnt_d = {BW{1'b0}};
                end
            end
            ST_SHIFT: begin
                if (qual_s) begin
                    sr_d      = sr_ins_s;
                    tmo_cnt_d = 16'd0;
                    if (bit_cnt_q == LAST_CNT) begin
                        word_done_s = 1'b1;
                        bit_cnt_d   = {BW{1'b0}};
                        state_d     = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (({1'b0, tmo_cnt_q} + 17'd1) == TMO_LIM) begin
                    tmo_ev_s  = 1'b1;
                    tmo_cnt_d = 16'd0;
                    bit_cnt_d = {BW{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = {BW{1'b0}};
                tmo_cnt_d = 16'd0;
            end
        endcase
    end

    assign push_s    = word_done_s;
    assign pop_s     = out_valid_q & out_ready;
    assign perr_ev_s = word_done_s & ~odd_par_ok(word_s, par_bit_s);

    // Two-entry output buffer; a pop always frees room for a same-cycle push.
    always_comb begin
        e0_d     = e0_q;
        e1_d     = e1_q;
        fill_d   = fill_q;
        ovf_ev_s = 1'b0;
        case ({push_s, pop_s})
            2'b01: begin
                e0_d   = e1_q;
                fill_d = fill_q - 2'd1;
            end
            2'b10: begin
                case (fill_q)
                    2'd0: begin
                        e0_d   = word_s;
                        fill_d = 2'd1;
                    end
                    2'd1: begin
                        e1_d   = word_s;
                        fill_d = 2'd2;
                    end
                    default: ovf_ev_s = 1'b1;
                endcase
            end
            2'b11: begin
                if (fill_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = word_s;
                end else begin
                    e0_d = word_s;
                end
            end
            default: begin
                fill_d = fill_q;
            end
        endcase
    end

    // Registered head word, valid and sticky error flags (a new event beats err_clr).
    always_comb begin
        out_valid_d = (fill_d != 2'd0);
        if (fill_d != 2'd0) begin
            out_data_d = e0_d;
        end else begin
            out_data_d = out_data_q;
        end
        ovf_d  = ovf_ev_s  | (ovf_q  & ~err_clr);
        tmo_d  = tmo_ev_s  | (tmo_q  & ~err_clr);
        perr_d = perr_ev_s | (perr_q & ~err_clr);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= {WL{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            tmo_cnt_q   <= 16'd0;
            e0_q        <= {WIDTH{1'b0}};
            e1_q        <= {WIDTH{1'b0}};
            fill_q      <= 2'd0;
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            perr_q      <= perr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign bit_cnt   = bit_cnt_q;
    assign ovf       = ovf_q;
    assign tmo       = tmo_q;
`ifdef PARITY_CHK_EN
    assign perr      = perr_q;
`else
    logic unused_perr_s;
    assign unused_perr_s = perr_q;
`endif

endmodule

// File: doc/cle02b_sdrd_capture.md
Name: cle02b_sdrd_capture

Overview:
Downstream consumer of the CLE02b security/sequencer PAL's serial response. On every qualified bus read into the PAL window (SSER low, BA13 low, BA12 high, BR_W high), it samples the PAL's response bit and deserialises the bits into words. Completed words go into a 2-entry output buffer with a valid/ready handshake toward the host-side register file. Includes a mid-word inactivity timeout and an overflow flag.

Parameters:
WIDTH, 8, data bits per word (2..16)
TIMEOUT, 1023, clk cycles without a qualified access before a partial word is discarded (1..65535)
MSB_FIRST, 1, 1 = first captured bit lands in bit WIDTH-1; 0 = first bit lands in bit 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
acc_stb  in  1  one-cycle pulse per completed bus access; SDRD, P12 and Q3 are stable in this cycle
SSER  in  1  serial-window select, active low
BA13  in  1  bus address bit 13
BA12  in  1  bus address bit 12
BR_W  in  1  bus read/not-write (1 = read)
SDRD  in  1  PAL response bit; driven only while Q3=0
P12  in  1  PAL alternate response bit; driven only while Q3=1
Q3  in  1  PAL state bit q3 (pin 16); selects the live response pin
out_data  out  WIDTH  head word of the output buffer
out_valid  out  1  buffer non-empty
out_ready  in  1  host accepts head word
bit_cnt  out  log2(WIDTH)+1  bits captured in the current partial word
ovf  out  1  sticky: a completed word was dropped because the buffer was full
tmo  out  1  sticky: a partial word was discarded by the timeout
err_clr  in  1  clears ovf, tmo (and perr if enabled)

Behaviour:
- Reset values: out_data=0, out_valid=0, bit_cnt=0, ovf=0, tmo=0, both buffer entries empty, FSM=IDLE, timeout counter=0. Reset wins over all other inputs in the same cycle, including mid-word and mid-handshake.
- Qualified access: qual = acc_stb & ~SSER & ~BA13 & BA12 & BR_W.
- Sampled bit: b = Q3 ? P12 : SDRD.
- Writes (BR_W=0) and out-of-window accesses never shift data and never reset the timeout counter.
- FSM IDLE: on qual, load b at the first bit position, set bit_cnt=1, go to SHIFT. If WIDTH==1 were allowed it would complete at once; the WIDTH>=2 bound forbids this.
- FSM SHIFT: on qual, insert b at the next position (MSB_FIRST: shift left, b into bit 0) and increment bit_cnt. When the WIDTH-th bit arrives, the word completes in the same cycle and the FSM returns to IDLE with bit_cnt=0.
- Completed words are pushed the cycle after the last bit. Capture latency is 1 cycle, so out_valid rises the cycle after the final qual when the buffer was empty.
- Timeout: in SHIFT, a counter increments every cycle without a qual and clears on qual. When it reaches TIMEOUT, the partial word is discarded, bit_cnt=0, FSM=IDLE and tmo is set. A qual arriving in the same cycle the count hits TIMEOUT takes priority: no timeout occurs.
- Buffer: 2-entry FIFO. Pop when out_valid & out_ready. Push and pop in the same cycle are always legal, including when full: the pop frees the slot, the push lands and ovf is not set. A push into a full buffer without a pop drops the new word and sets ovf; existing contents are unchanged.
- out_data is registered. When the buffer is empty it holds its last value. Its value is only meaningful while out_valid=1.
- err_clr: clears the flags next cycle. If a new error event occurs in the same cycle as err_clr, the event wins (the flag stays set).

Optional Feature:
PARITY_CHK_EN: when defined, each word is WIDTH+1 bits, with the final captured bit being odd parity over the WIDTH data bits. Adds output perr (1 bit, sticky, reset 0, cleared by err_clr). A word with bad parity is still pushed (data only, parity stripped) and sets perr. When not defined, words are exactly WIDTH bits, the perr port is absent, and no parity bit is consumed.

Test Plan:
- Reset, then 8 quals with Q3=0 and SDRD=1,0,1,0,0,1,0,1 (MSB_FIRST=1) -> out_valid=1 one cycle after the 8th qual, out_data=0xA5, bit_cnt=0.
- Same sequence with Q3=1 on bits 4..7, P12 carrying those bits and SDRD held at the opposite value -> out_data=0xA5 (proves the Q3 mux).
- Interleave writes (BR_W=0) and BA12=0 accesses among the 8 reads -> ignored; out_data unchanged from 0xA5 and bit_cnt only counts qualified reads.
- out_ready=0, push 3 words 0x11, 0x22, 0x33 -> ovf=1; then out_ready=1 pops 0x11, then 0x22; 0x33 never appears. Separately, a push with a simultaneous pop while full -> no ovf.
- TIMEOUT=16: 3 quals, then 16 idle cycles -> tmo=1, bit_cnt=0; the next 8 quals form a clean word. Qual on idle cycle 16 -> no tmo.
- PARITY_CHK_EN: 9 bits of 0x5A with parity=1 -> perr=0; with parity=0 -> perr=1 and out_data=0x5A. Assert rst mid-word at bit_cnt=5 -> all outputs return to reset values next cycle.
